// File: rtl/seq_multiplier_if.sv
// Start/ready multiply handshake between the EX stage (master) and the iterative multiplier (slave).
// Master raises start with A/B while the slave is idle; slave pulses ready for one cycle when out is new.
interface seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 ready;
   logic [2*WIDTH-1:0]   out;

   modport master (output start, output A, output B, input ready, input out);
   modport slave  (input start, input A, input B, output ready, output out);
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit retired per clock, sign applied once at the end.
// Fixed latency of WIDTH+1 edges from the accepting edge to the ready cycle.
module seq_multiplier #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   seq_multiplier_if.slave    bus,
   output logic [1:0]         dbg_state
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     out_q, out_d;
   logic [WIDTH-1:0]  a_mag, b_mag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         out_q    <= out_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      out_d    = out_q;
      // The most negative operand negates to itself, which is still the correct unsigned magnitude.
      a_mag = (SIGNED && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
      b_mag = (SIGNED && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = BUSY;
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               count_d  = '0;
               neg_d    = SIGNED && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            end
         end
         BUSY: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) state_d = SIGN;
         end
         SIGN: begin
            out_d   = neg_q ? (~acc_q + PW'(1)) : acc_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ready is a pure state decode so an asynchronous reset drops it immediately.
   assign bus.ready = (state_q == DONE);
   assign bus.out   = out_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a signed and an unsigned instance driven identically, checked by a
// scoreboard fed from the driver and drained by a monitor whenever ready is seen.
module tb_seq_multiplier;
   localparam int W   = 32;
   localparam int LAT = 33;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seq_multiplier_if #(.WIDTH(W)) ifs ();
   seq_multiplier_if #(.WIDTH(W)) ifu ();
   logic [1:0] st_s, st_u;

   seq_multiplier #(.WIDTH(W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(ifs), .dbg_state(st_s));
   seq_multiplier #(.WIDTH(W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(ifu), .dbg_state(st_u));

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] exp_q[$];
   logic [63:0] exp_u_q[$];
   int          iss_q[$];
   int          iss_u_q[$];
   logic [63:0] held_s = '0;
   logic [63:0] held_u = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: plain 64-bit integer multiplication.
   function automatic logic [63:0] ref_s(input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
   endfunction

   function automatic logic [63:0] ref_u(input logic [31:0] a, input logic [31:0] b);
      longint unsigned x, y;
      x = 64'(a);
      y = 64'(b);
      return x * y;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic mon_one(input int k, input logic rdy, input logic [63:0] o);
      logic [63:0] e;
      int          t;
      if (rdy === 1'b1) begin
         if ((k == 0) ? (exp_q.size() == 0) : (exp_u_q.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ready dut%0d: got ready=1 out=%h, expected no pulse", k, o);
         end else begin
            if (k == 0) begin
               e = exp_q.pop_front();  t = iss_q.pop_front();  held_s = e;
            end else begin
               e = exp_u_q.pop_front(); t = iss_u_q.pop_front(); held_u = e;
            end
            check((k == 0) ? "product_signed" : "product_unsigned", o, e);
            check((k == 0) ? "latency_signed" : "latency_unsigned", 64'(cyc - t), 64'(LAT));
         end
      end else begin
         check((k == 0) ? "ready_low_signed" : "ready_low_unsigned", 64'(rdy), 64'(0));
         check((k == 0) ? "out_hold_signed" : "out_hold_unsigned", o, (k == 0) ? held_s : held_u);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon_one(0, ifs.ready, ifs.out);
         mon_one(1, ifu.ready, ifu.out);
      end
   end

   task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
      ifs.start = s; ifs.A = a; ifs.B = b;
      ifu.start = s; ifu.A = a; ifu.B = b;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive(1'b1, a, b);
      @(posedge clk);
      #1;
      exp_q.push_back(ref_s(a, b));
      exp_u_q.push_back(ref_u(a, b));
      iss_q.push_back(cyc);
      iss_u_q.push_back(cyc);
      drive(1'b0, $urandom, $urandom);
   endtask

   task automatic wait_done(input bit noisy, input bit inject9, output bit got);
      got = 1'b0;
      for (int i = 0; i < LAT + 6 && !got; i++) begin
         @(negedge clk);
         if (ifs.ready === 1'b1) begin
            got = 1'b1;
            drive(1'b0, $urandom, $urandom);
         end else if (inject9 && i == 4) begin
            drive(1'b1, 32'd9, 32'd9);
         end else if (noisy) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom);
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: got no ready within %0d cycles, expected a pulse", LAT + 6);
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit noisy,
                        input bit inject9, input int gap);
      bit got;
      issue(a, b);
      wait_done(noisy, inject9, got);
      repeat (gap) begin
         @(negedge clk);
         drive(1'b0, $urandom, $urandom);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready_s"}, 64'(ifs.ready), 64'(0));
      check({tag, "_ready_u"}, 64'(ifu.ready), 64'(0));
      check({tag, "_out_s"}, ifs.out, 64'(0));
      check({tag, "_out_u"}, ifu.out, 64'(0));
      check({tag, "_state_s"}, 64'(st_s), 64'(0));
      check({tag, "_state_u"}, 64'(st_u), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] da[10];
      logic [31:0] db[10];
      bit          got;
      da = '{32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
             32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1};
      db = '{32'd5, 32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
             32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1};

      drive(1'b0, '0, '0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b1;

      // Directed corner operands, issued back-to-back.
      for (int i = 0; i < 10; i++) do_op(da[i], db[i], 1'b0, 1'b0, 0);

      // Start/A/B activity while busy, including start with 9*9 at the fifth edge.
      do_op(32'd12345, 32'hFFFF_FD4A, 1'b1, 1'b1, 2);

      // Abort mid-operation.
      issue($urandom, $urandom);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_reset_state("abort");
      exp_q.delete(); exp_u_q.delete(); iss_q.delete(); iss_u_q.delete();
      held_s = '0; held_u = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (LAT + 5) @(negedge clk);
      do_op(32'd2, 32'd2, 1'b0, 1'b0, 1);

      // Reset while ready is high drops it without a clock edge.
      issue(32'hDEAD_BEEF, 32'h1234_5678);
      wait_done(1'b0, 1'b0, got);
      #1 rst = 1'b0;
      #1;
      check_reset_state("ready_abort");
      exp_q.delete(); exp_u_q.delete(); iss_q.delete(); iss_u_q.delete();
      held_s = '0; held_u = '0;
      @(posedge clk);
      #3 rst = 1'b1;

      for (int i = 0; i < 30; i++)
         do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size() + exp_u_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
